csa_accum_ctrl: RTL

//  Sequencer for a carry-save multi-operand adder. Accepts NUM_OPS operands one per beat over a

---
 rtl/csa_accum_ctrl_if.sv | 24 ++
 rtl/csa_accum_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/csa_accum_ctrl_if.sv
// Operand and result handshakes between an operand source/result consumer and csa_accum_ctrl.
// A beat transfers when valid & ready are both high at a rising clock edge. A raised valid is held,
// with its payload stable, until that transfer happens. ready may depend on state only.
interface csa_accum_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
);
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_data;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;

  modport master (
    output op_valid, op_data, res_ready,
    input  op_ready, res_valid, res_data
  );

  modport slave (
    input  op_valid, op_data, res_ready,
    output op_ready, res_valid, res_data
  );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Carry-save multi-operand accumulator sequencer: compresses NUM_OPS operands into sum/carry
// registers, then resolves them in one ripple-carry cycle and offers the binary total.
module csa_accum_ctrl #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4,
  parameter int ACC_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  csa_accum_ctrl_if.slave     bus,
  output logic [7:0]          op_count,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  if (NUM_OPS < 1 || NUM_OPS > 255) begin : g_bad_num_ops
    $error("csa_accum_ctrl: NUM_OPS must be in 1..255");
  end
  if (ACC_W < WIDTH + $clog2(NUM_OPS)) begin : g_bad_acc_w
    $error("csa_accum_ctrl: ACC_W too narrow for WIDTH and NUM_OPS");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(NUM_OPS);

  state_t           state;
  logic [ACC_W-1:0] sum_reg;
  logic [ACC_W-1:0] carry_reg;
  logic [ACC_W-1:0] op_ext;
  logic [ACC_W-1:0] maj;
  logic [7:0]       next_count;

  assign op_ext     = ACC_W'(bus.op_data);
  assign maj        = (sum_reg & carry_reg) | (sum_reg & op_ext) | (carry_reg & op_ext);
  assign next_count = op_count + 8'd1;

  assign bus.op_ready = (state == IDLE) || (state == ACCUM);
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sum_reg       <= '0;
      carry_reg     <= '0;
      op_count      <= 8'd0;
      bus.res_data  <= '0;
      bus.res_valid <= 1'b0;
    end else if (flush) begin
      // Abort wins over any transfer on the same edge; res_data keeps its last value.
      state         <= IDLE;
      sum_reg       <= '0;
      carry_reg     <= '0;
      op_count      <= 8'd0;
      bus.res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            sum_reg   <= op_ext;
            carry_reg <= '0;
            op_count  <= 8'd1;
            state     <= (LAST_COUNT == 8'd1) ? RESOLVE : ACCUM;
          end
        end
        ACCUM: begin
          if (bus.op_valid) begin
            sum_reg   <= sum_reg ^ carry_reg ^ op_ext;
            carry_reg <= maj << 1;
            op_count  <= next_count;
            if (next_count == LAST_COUNT) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          bus.res_data  <= sum_reg + carry_reg;
          bus.res_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            op_count      <= 8'd0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
